// File: rtl/cbus_mem_responder_pkg.sv
// CBus shared types: request/response bundles, burst length and size codes.
// Imported by the memory responder and its RAM array.
package cbus_mem_responder_pkg;

  typedef logic [31:0] i32;
  typedef logic [3:0]  i4;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  // Encoded as beats-1.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef struct packed {
    logic      valid;
    logic      is_write;
    msize_t    size;
    i32        addr;
    i4         strobe;
    i32        data;
    cbus_len_t len;
  } cbus_req_t;

  typedef struct packed {
    logic ready;
    logic last;
    i32   data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_mem_responder_array.sv
// Byte-strobed word RAM: one write port, one combinational read port.
// Ports: clk, we, waddr, strobe, wdata, raddr, rdata. Contents are not reset.
module cbus_mem_responder_array
  import cbus_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  i4                    strobe,
  input  i32                   wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output i32                   rdata
);

  i32 mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe[b]) begin
          mem[waddr][8*b+:8] <= wdata[8*b+:8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cbus_mem_responder.sv
// CBus memory responder: programmable-latency single/burst reads and writes.
// Ports: clk, resetn (async low), req (cbus_req_t), resp (cbus_resp_t), err (sticky).
module cbus_mem_responder
  import cbus_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  req,
  output cbus_resp_t resp,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

  typedef logic [ADDR_BITS-1:0] widx_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] nbeat_q, nbeat_d;
  widx_t      base_q, base_d;
  logic       wr_q, wr_d;
  logic       ready_q, ready_d;
  logic       last_q, last_d;
  logic       err_q, err_d;
  logic       we;
  widx_t      widx;
  i32         rdata;
  logic       unused;

  assign unused = ^{req.size, req.addr[31:ADDR_BITS+2],
                    req.addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      nbeat_q <= '0;
      base_q  <= '0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nbeat_q <= nbeat_d;
      base_q  <= base_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // ready/last are computed one edge ahead so they leave flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nbeat_d = nbeat_q;
    base_d  = base_q;
    wr_d    = wr_q;
    ready_d = 1'b0;
    last_d  = 1'b0;
    err_d   = err_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req.valid) begin
          wr_d    = req.is_write;
          base_d  = req.addr[ADDR_BITS+1:2];
          nbeat_d = req.len;
          idx_d   = '0;
          cnt_d   = LAT;
          if (LAT == 4'd0) begin
            state_d = BURST;
            ready_d = 1'b1;
            last_d  = (req.len == MLEN1);
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req.valid) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = BURST;
          ready_d = 1'b1;
          last_d  = (nbeat_q == 4'd0);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      BURST: begin
        if (!req.valid) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          we = wr_q;
          if (idx_q == nbeat_q) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            ready_d = 1'b1;
            last_d  = (idx_q + 4'd1 == nbeat_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Index wraps naturally at the RAM size.
  assign widx = base_q + widx_t'(idx_q);

  cbus_mem_responder_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (widx),
    .strobe(req.strobe),
    .wdata (req.data),
    .raddr (widx),
    .rdata (rdata)
  );

  always_comb begin
    resp       = '0;
    resp.ready = ready_q;
    resp.last  = last_q;
    resp.data  = (ready_q && !wr_q) ? rdata : '0;
  end

  assign err = err_q;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Randomised bench for cbus_mem_responder against a transaction-level model.
// Model: word array plus per-cycle schedule derived from accept time.
module tb_cbus_mem_responder;
  import cbus_mem_responder_pkg::*;

  localparam int AB  = 10;
  localparam int LAT = 2;
  localparam int N   = 1 << AB;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  cbus_req_t  req;
  cbus_resp_t resp;
  logic       err;

  cbus_mem_responder #(
    .ADDR_BITS(AB),
    .LATENCY  (LAT)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .req   (req),
    .resp  (resp),
    .err   (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  logic        exp_ready, exp_last, exp_err;
  logic [31:0] exp_data;
  bit          err_m;
  logic [31:0] mem_m [N];
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  int          obs_first;
  logic [31:0] obs_q [$];
  int          lens [5] = '{0, 1, 3, 7, 15};

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(resp.ready), 32'(exp_ready));
      chk("last", 32'(resp.last), 32'(exp_last));
      chk("data", resp.data, exp_data);
      chk("err", 32'(err), 32'(exp_err));
    end
  end

  function automatic logic [31:0] obs(int i);
    if (i < obs_q.size()) return obs_q[i];
    return 'x;
  endfunction

  task automatic idle(int n);
    req.valid = 1'b0;
    exp_ready = 1'b0;
    exp_last  = 1'b0;
    exp_data  = '0;
    exp_err   = err_m;
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after a rising edge; k=0 is the accept cycle.
  task automatic xact(input bit wr, input logic [31:0] addr,
                      input int nb, input int drop_cyc,
                      input int rst_cyc);
    int base;
    int beat;
    int w;
    bit inb;
    bit dropped;
    base = int'(addr[AB+1:2]);
    dropped = 1'b0;
    obs_first = -1;
    obs_q.delete();
    for (int k = 0; k < 64; k++) begin
      beat = k - (LAT + 1);
      inb = (beat >= 0) && (beat <= nb);
      w = (base + (inb ? beat : 0)) % N;
      if (dropped) begin
        req.valid = 1'b0;
        exp_ready = 1'b0;
        exp_last  = 1'b0;
        exp_data  = '0;
        exp_err   = err_m;
      end else begin
        req.valid    = !(drop_cyc >= 0 && k >= drop_cyc);
        req.is_write = wr;
        req.size     = MSIZE4;
        req.addr     = addr;
        req.len      = cbus_len_t'(nb[3:0]);
        req.data     = wdat[inb ? beat : 0];
        req.strobe   = wstb[inb ? beat : 0];
        exp_ready = inb;
        exp_last  = inb && (beat == nb);
        exp_data  = (inb && !wr) ? mem_m[w] : 32'h0;
        exp_err   = err_m;
      end
      if (k == rst_cyc) begin
        chk_en = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_ready", 32'(resp.ready), 32'h0);
        chk("rst_last", 32'(resp.last), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        req.valid = 1'b0;
        err_m = 1'b0;
        exp_ready = 1'b0;
        exp_last  = 1'b0;
        exp_data  = '0;
        exp_err   = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        return;
      end
      @(negedge clk);
      if (resp.ready === 1'b1) begin
        if (obs_first < 0) obs_first = k;
        if (!wr) obs_q.push_back(resp.data);
      end
      @(posedge clk);
      if (dropped) begin
        #1;
        return;
      end
      if (!req.valid) begin
        dropped = 1'b1;
        err_m = 1'b1;
      end else if (wr && inb) begin
        for (int b = 0; b < 4; b++)
          if (wstb[beat][b])
            mem_m[w][8*b+:8] = wdat[beat][8*b+:8];
      end
      #1;
      if (!dropped && inb && beat == nb) return;
    end
    errors++;
    $display("FAIL xact_bound: got no end want end at %0t", $time);
  endtask

  task automatic fill_rand();
    for (int j = 0; j < 16; j++) begin
      wdat[j] = $urandom;
      wstb[j] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic rand_run(int n);
    bit wr;
    for (int i = 0; i < n; i++) begin
      fill_rand();
      wr = 1'($urandom_range(0, 1));
      xact(wr, $urandom, lens[$urandom_range(0, 4)], -1, -1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
  endtask

  initial begin
    req = '0;
    err_m = 1'b0;
    exp_ready = 1'b0;
    exp_last  = 1'b0;
    exp_data  = '0;
    exp_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(resp.ready), 32'h0);
    chk("reset_last", 32'(resp.last), 32'h0);
    chk("reset_data", resp.data, 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    for (int i = 0; i < N / 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        wdat[j] = $urandom;
        wstb[j] = 4'hF;
      end
      xact(1'b1, 32'(i * 64), 15, -1, -1);
    end

    wdat[0] = 32'hDEADBEEF;
    wstb[0] = 4'hF;
    xact(1'b1, 32'h10, 0, -1, -1);
    idle(1);
    xact(1'b0, 32'h10, 0, -1, -1);
    chk("t1_latency", 32'(obs_first), 32'd3);
    chk("t1_data", obs(0), 32'hDEADBEEF);

    for (int j = 0; j < 4; j++) begin
      wdat[j] = 32'(j + 1);
      wstb[j] = 4'hF;
    end
    xact(1'b1, 32'h100, 3, -1, -1);
    xact(1'b0, 32'h100, 3, -1, -1);
    for (int j = 0; j < 4; j++)
      chk("t2_data", obs(j), 32'(j + 1));

    wdat[0] = 32'h11223344;
    wstb[0] = 4'hF;
    xact(1'b1, 32'h20, 0, -1, -1);
    wdat[0] = 32'hAABBCCDD;
    wstb[0] = 4'b0101;
    xact(1'b1, 32'h20, 0, -1, -1);
    xact(1'b0, 32'h20, 0, -1, -1);
    chk("t3_partial", obs(0), 32'h11BB33DD);

    xact(1'b0, 32'hF000_0FFA, 15, -1, -1);
    chk("t4_beats", 32'(obs_q.size()), 32'd16);
    chk("t4_wrap", obs(2), mem_m[0]);

    rand_run(60);

    fill_rand();
    xact(1'b1, 32'h200, 7, LAT + 3, -1);
    chk("t5_err", 32'(err), 32'h1);
    xact(1'b0, 32'h200, 7, -1, -1);

    xact(1'b0, 32'h300, 3, -1, 1);
    fill_rand();
    xact(1'b1, 32'h300, 7, -1, LAT + 4);
    xact(1'b0, 32'h300, 7, -1, -1);
    fill_rand();
    xact(1'b1, 32'h340, 3, -1, -1);
    xact(1'b0, 32'h340, 3, -1, -1);
    chk("t6_b2b_latency", 32'(obs_first), 32'(LAT + 1));

    rand_run(30);
    idle(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
